// File: rtl/riscv_trace_pkg.sv
// Shared types for the riscv event tracer.
// Record layout, kind encoding and kind-mask bit positions.
package riscv_trace_pkg;

  localparam int unsigned TR_ADDR_W = 9;
  localparam int unsigned TR_DATA_W = 32;
  localparam int unsigned TR_TS_W   = 32;

  localparam int unsigned MASK_REG_WR = 0;
  localparam int unsigned MASK_MEM_WR = 1;
  localparam int unsigned MASK_MEM_RD = 2;

  typedef enum logic [1:0] {
    REG_WR       = 2'd0,
    MEM_WR       = 2'd1,
    MEM_RD       = 2'd2,
    MEM_CONFLICT = 2'd3
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e            kind;
    logic [TR_ADDR_W-1:0]   idx;
    logic [TR_DATA_W-1:0]   data;
    logic [TR_TS_W-1:0]     stamp;
  } trace_entry_t;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Two-write / one-read first-word-fall-through FIFO.
// The head holds its last shown value once the FIFO drains.
module trace_fifo_2w1r
  import riscv_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter type entry_t = trace_entry_t
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 push0_i,
  input  logic                 push1_i,
  input  entry_t               d0_i,
  input  entry_t               d1_i,
  input  logic                 pop_i,
  output entry_t               head_o,
  output logic                 valid_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  entry_t        mem_q [DEPTH];
  entry_t        last_q;
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d, wp1;
  logic [LW-1:0] lvl_q, lvl_d;
  logic          do_pop;

  assign valid_o = lvl_q != '0;
  assign level_o = lvl_q;
  assign head_o  = valid_o ? mem_q[rp_q] : last_q;
  assign do_pop  = pop_i && valid_o;
  assign wp1     = wp_q + 1'b1;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    lvl_d = lvl_q;
    if (clear_i) begin
      wp_d  = '0;
      rp_d  = '0;
      lvl_d = '0;
    end else begin
      wp_d  = wp_q + AW'(push0_i) + AW'(push1_i);
      rp_d  = rp_q + AW'(do_pop);
      lvl_d = lvl_q + LW'(push0_i) + LW'(push1_i) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      last_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      lvl_q  <= lvl_d;
      if (valid_o) last_q <= mem_q[rp_q];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      if (push0_i) mem_q[wp_q] <= d0_i;
      if (push1_i) mem_q[wp1]  <= d1_i;
    end
  end

endmodule

// File: rtl/riscv_trace_buffer.sv
// Event tracer: decodes reg/mem debug taps into timestamped records,
// applies the drop policy and drains them over valid/ready.
module riscv_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = TR_ADDR_W,
  parameter int unsigned DATA_W = TR_DATA_W,
  parameter int unsigned TS_W   = TR_TS_W,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [2:0]             kind_mask,
  input  logic                   clear,
  input  logic                   reg_write_sig,
  input  logic [4:0]             reg_num,
  input  logic [DATA_W-1:0]      reg_data,
  input  logic                   wr,
  input  logic                   rd,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [1:0]             trace_kind,
  output logic [ADDR_W-1:0]      trace_idx,
  output logic [DATA_W-1:0]      trace_data,
  output logic [TS_W-1:0]        trace_time,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count
);

  localparam int unsigned LW  = $clog2(DEPTH) + 1;
  localparam int unsigned SW  = LW + 1;
  localparam int unsigned DW1 = DROP_W + 1;

  typedef struct packed {
    trace_kind_e        kind;
    logic [ADDR_W-1:0]  idx;
    logic [DATA_W-1:0]  data;
    logic [TS_W-1:0]    stamp;
  } entry_t;

  logic [TS_W-1:0]   ts_q;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              ovf_q, ovf_d;
  logic              mem_ev, reg_ev, pop, push0, push1;
  entry_t            mem_e, reg_e, e0, head;
  logic [LW-1:0]     lvl;
  logic [SW-1:0]     space;
  logic [1:0]        n_ev, n_push, n_drop;
  logic [DW1-1:0]    drop_sum;

  always_comb begin
    mem_e       = '0;
    mem_e.idx   = addr;
    mem_e.stamp = ts_q;
    unique case (1'b1)
      wr && rd: begin
        mem_e.kind = MEM_CONFLICT;
        mem_e.data = wr_data;
      end
      wr && !rd: begin
        mem_e.kind = MEM_WR;
        mem_e.data = wr_data;
      end
      rd && !wr: begin
        mem_e.kind = MEM_RD;
        mem_e.data = rd_data;
      end
      default: mem_e.kind = MEM_WR;
    endcase
  end

  assign reg_e = '{kind: REG_WR, idx: ADDR_W'(reg_num),
                   data: reg_data, stamp: ts_q};

  // Conflicts bypass the mask; clear discards everything sampled with it.
  assign mem_ev = en && !clear &&
                  ((wr && rd) ||
                   (wr && !rd && kind_mask[MASK_MEM_WR]) ||
                   (rd && !wr && kind_mask[MASK_MEM_RD]));
  assign reg_ev = en && !clear && reg_write_sig &&
                  kind_mask[MASK_REG_WR];

  assign e0     = mem_ev ? mem_e : reg_e;
  assign n_ev   = {1'b0, mem_ev} + {1'b0, reg_ev};
  assign pop    = trace_valid && trace_ready;
  assign space  = SW'(DEPTH) - SW'(lvl) + SW'(pop);
  assign n_push = (space >= SW'(n_ev)) ? n_ev : space[1:0];
  assign n_drop = n_ev - n_push;
  assign push0  = n_push != 2'd0;
  assign push1  = n_push == 2'd2;

  assign drop_sum = {1'b0, drop_q} + DW1'(n_drop);

  always_comb begin
    drop_d = drop_q;
    ovf_d  = ovf_q;
    if (clear) begin
      drop_d = '0;
      ovf_d  = 1'b0;
    end else if (n_drop != 2'd0) begin
      drop_d = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
      ovf_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q   <= '0;
      drop_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      ts_q   <= ts_q + 1'b1;
      drop_q <= drop_d;
      ovf_q  <= ovf_d;
    end
  end

  trace_fifo_2w1r #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .clear_i (clear),
    .push0_i (push0),
    .push1_i (push1),
    .d0_i    (e0),
    .d1_i    (reg_e),
    .pop_i   (pop),
    .head_o  (head),
    .valid_o (trace_valid),
    .level_o (lvl)
  );

  assign level      = lvl;
  assign trace_kind = head.kind;
  assign trace_idx  = head.idx;
  assign trace_data = head.data;
  assign trace_time = head.stamp;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// Bench for riscv_trace_buffer: directed plan steps then random traffic,
// checked against a queue-based record model.
module tb_riscv_trace_buffer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [2:0]  kind_mask;
  logic        clear;
  logic        reg_write_sig;
  logic [4:0]  reg_num;
  logic [31:0] reg_data;
  logic        wr, rd;
  logic [8:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic        trace_ready;
  logic        trace_valid;
  logic [1:0]  trace_kind;
  logic [8:0]  trace_idx;
  logic [31:0] trace_data;
  logic [31:0] trace_time;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          kind;
    int          idx;
    logic [31:0] data;
    logic [31:0] tm;
  } rec_t;

  rec_t        q[$];
  rec_t        last;
  int unsigned t;
  int          mdrop;
  bit          movf;

  always #5 clk = ~clk;

  riscv_trace_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .kind_mask(kind_mask),
    .clear(clear), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
    .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_kind(trace_kind),
    .trace_idx(trace_idx), .trace_data(trace_data),
    .trace_time(trace_time), .level(level), .overflow(overflow),
    .drop_count(drop_count)
  );

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last  = '{0, 0, 32'h0, 32'h0};
    t     = 0;
    mdrop = 0;
    movf  = 0;
  endtask

  task automatic idle();
    en = 1'b1; kind_mask = 3'b111; clear = 1'b0;
    reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
    wr = 1'b0; rd = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
  endtask

  // Advance one clock: model the edge from current inputs, then compare.
  task automatic step();
    rec_t ev[$];
    bit   exp_v;
    ev = {};
    if (en) begin
      if (wr && rd) ev.push_back('{3, int'(addr), wr_data, t});
      else if (wr && kind_mask[1]) ev.push_back('{1, int'(addr), wr_data, t});
      else if (rd && !wr && kind_mask[2])
        ev.push_back('{2, int'(addr), rd_data, t});
      if (reg_write_sig && kind_mask[0])
        ev.push_back('{0, int'(reg_num), reg_data, t});
    end
    if (clear) begin
      q.delete();
      mdrop = 0;
      movf  = 0;
    end else begin
      if (q.size() > 0 && trace_ready) void'(q.pop_front());
      foreach (ev[i]) begin
        if (q.size() < DEPTH) q.push_back(ev[i]);
        else begin
          mdrop = (mdrop < 65535) ? mdrop + 1 : 65535;
          movf  = 1;
        end
      end
    end
    t++;
    @(posedge clk);
    #1;
    exp_v = q.size() > 0;
    if (exp_v) last = q[0];
    check("valid", trace_valid, exp_v);
    check("kind", trace_kind, last.kind);
    check("idx", trace_idx, last.idx);
    check("data", trace_data, last.data);
    check("time", trace_time, last.tm);
    check("level", level, q.size());
    check("overflow", overflow, movf);
    check("drop_count", drop_count, mdrop);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_valid"}, trace_valid, 0);
    check({tag, "_kind"}, trace_kind, 0);
    check({tag, "_idx"}, trace_idx, 0);
    check({tag, "_data"}, trace_data, 0);
    check({tag, "_time"}, trace_time, 0);
    check({tag, "_level"}, level, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_drop"}, drop_count, 0);
  endtask

  initial begin
    reset = 1'b1;
    trace_ready = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b0;
    model_reset();

    // Single register write sampled at stamp 3.
    repeat (3) step();
    reg_write_sig = 1'b1; reg_num = 5'd5; reg_data = 32'h0000_000A;
    step();
    check("tp1_kind", trace_kind, 0);
    check("tp1_idx", trace_idx, 5);
    check("tp1_data", trace_data, 32'hA);
    check("tp1_time", trace_time, 3);
    check("tp1_level", level, 1);
    idle(); trace_ready = 1'b1;
    step();
    check("tp1_drained", trace_valid, 0);

    // Memory write plus register write in one cycle: memory first.
    trace_ready = 1'b0;
    wr = 1'b1; addr = 9'd20; wr_data = 32'hDEAD_BEEF;
    reg_write_sig = 1'b1; reg_num = 5'd7; reg_data = 32'h1;
    step();
    check("dual_kind", trace_kind, 1);
    check("dual_idx", trace_idx, 20);
    check("dual_data", trace_data, 32'hDEAD_BEEF);
    check("dual_level", level, 2);
    idle(); trace_ready = 1'b1;
    step();
    check("dual_second_kind", trace_kind, 0);
    check("dual_second_idx", trace_idx, 7);
    step();

    // Conflict survives an all-zero mask.
    trace_ready = 1'b0;
    kind_mask = 3'b000; wr = 1'b1; rd = 1'b1;
    addr = 9'd4; wr_data = 32'h11; rd_data = 32'h99;
    step();
    check("conf_kind", trace_kind, 3);
    check("conf_idx", trace_idx, 4);
    check("conf_data", trace_data, 32'h11);
    idle(); trace_ready = 1'b1;
    step();

    // Masked and disabled kinds leave no trace.
    trace_ready = 1'b0;
    kind_mask = 3'b001; wr = 1'b1; addr = 9'd9;
    step();
    kind_mask = 3'b111; en = 1'b0; rd = 1'b1; wr = 1'b0;
    reg_write_sig = 1'b1;
    step();
    check("mask_level", level, 0);

    // Overfill with single events.
    idle();
    for (int i = 0; i < 18; i++) begin
      reg_write_sig = 1'b1; reg_num = 5'(i); reg_data = 32'(i * 3);
      step();
    end
    check("full_level", level, 16);
    check("full_ovf", overflow, 1);
    check("full_drop", drop_count, 2);

    // One slot free, dual event: memory kept, register dropped.
    idle(); trace_ready = 1'b1;
    step();
    trace_ready = 1'b0;
    rd = 1'b1; addr = 9'd33; rd_data = 32'hCAFE;
    reg_write_sig = 1'b1; reg_num = 5'd2; reg_data = 32'h5;
    step();
    check("slot1_level", level, 16);
    check("slot1_drop", drop_count, 3);

    // Full, pop and dual push together.
    trace_ready = 1'b1;
    wr = 1'b1; rd = 1'b0; addr = 9'd40; wr_data = 32'h77;
    step();
    check("popfull_level", level, 16);
    check("popfull_drop", drop_count, 4);

    // Clear with an event pending.
    trace_ready = 1'b0;
    clear = 1'b1;
    step();
    check("clr_level", level, 0);
    check("clr_valid", trace_valid, 0);
    check("clr_ovf", overflow, 0);
    check("clr_drop", drop_count, 0);
    idle();
    reg_write_sig = 1'b1; reg_num = 5'd9; reg_data = 32'h9;
    step();
    check("clr_time", trace_time, t - 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      en            = ($urandom_range(9) != 0);
      kind_mask     = 3'($urandom);
      clear         = ($urandom_range(39) == 0);
      reg_write_sig = 1'($urandom);
      reg_num       = 5'($urandom);
      reg_data      = $urandom;
      wr            = 1'($urandom);
      rd            = 1'($urandom);
      addr          = 9'($urandom);
      wr_data       = $urandom;
      rd_data       = $urandom;
      trace_ready   = ($urandom_range(2) == 0);
      step();
    end

    // Asynchronous reset between edges.
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_zero("areset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    idle();
    trace_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; addr = 9'(i + 100); wr_data = $urandom;
      reg_write_sig = 1'b1; reg_num = 5'(i); reg_data = $urandom;
      step();
    end
    check("post_reset_level", level, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_trace_buffer.md
Name: riscv_trace_buffer

Overview:
Synthesizable event tracer for the riscv core. It captures register-file writes and data-memory accesses as timestamped records into a parametrised FIFO, and drains them over a valid/ready stream. It sits beside the riscv top, tapping the same debug signals (reg_write_sig/reg_num/reg_data, wr/rd/addr/wr_data/rd_data). It adds kind filtering, conflict detection, dual-event capture per cycle, overflow accounting and back-pressure.

Parameters:
DEPTH, 16, FIFO entries; power of two, at least 2
ADDR_W, 9, memory address width
DATA_W, 32, register and memory data width
TS_W, 32, timestamp counter width
DROP_W, 16, dropped-event counter width

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
en  in  1  capture enable; when 0, no events are pushed or dropped
kind_mask  in  3  bit0 REG_WR, bit1 MEM_WR, bit2 MEM_RD; 1 = capture the kind (MEM_CONFLICT is always captured when en=1)
clear  in  1  synchronous flush of FIFO, overflow and drop_count
reg_write_sig  in  1  register write strobe
reg_num  in  5  destination register
reg_data  in  DATA_W  register write data
wr  in  1  memory write strobe
rd  in  1  memory read strobe
addr  in  ADDR_W  memory address
wr_data  in  DATA_W  memory write data
rd_data  in  DATA_W  memory read data
trace_valid  out  1  head record available
trace_ready  in  1  consumer accepts head
trace_kind  out  2  0 REG_WR, 1 MEM_WR, 2 MEM_RD, 3 MEM_CONFLICT
trace_idx  out  ADDR_W  reg_num (zero-extended) or addr
trace_data  out  DATA_W  captured data
trace_time  out  TS_W  cycle stamp of the event
level  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky; set when any event is dropped
drop_count  out  DROP_W  saturating count of dropped events

Behaviour:
- Reset: FIFO empty, trace_valid=0, trace_kind/idx/data/time=0, level=0, overflow=0, drop_count=0, timestamp=0.
- Timestamp: free-running, increments every clk after reset, wraps modulo 2^TS_W, not affected by clear. An event sampled at edge N carries stamp value N.
- Event decode (sampled at clk edge, en=1):
  - wr&~rd gives MEM_WR with data=wr_data.
  - rd&~wr gives MEM_RD with data=rd_data.
  - wr&rd gives MEM_CONFLICT with data=wr_data.
  - reg_write_sig gives REG_WR with idx={0,reg_num} and data=reg_data. x0 writes are recorded as-is.
  - Masked kinds are ignored entirely: not pushed, not counted.
- Up to 2 events per cycle. Order: memory event first, then REG_WR.
- Free space = DEPTH - level + (pop this cycle ? 1 : 0), where pop = trace_valid & trace_ready.
  - space ≥ 2: push both events.
  - space = 1: push the memory event and drop REG_WR.
  - space = 0: drop all events.
- Each dropped event increments drop_count by 1 (saturates at all-ones; +2 possible in one cycle) and sets overflow.
- FIFO is first-word-fall-through. An event at edge N appears on trace_* with trace_valid=1 after edge N (latency 1) if the FIFO was empty.
- trace_* outputs are stable while trace_valid=1 and trace_ready=0. When trace_valid=0, the outputs hold their last value.
- Pointers wrap modulo DEPTH. level is never greater than DEPTH.
- clear has priority over push and pop in the same cycle: FIFO empty, level=0, overflow=0, drop_count=0 after the edge. Events in the clear cycle are discarded and not counted.
- Asynchronous reset asserted mid-operation returns everything to the reset values immediately. No partial record survives.

Decomposition:
- Package riscv_trace_pkg: trace_kind_e enum (REG_WR, MEM_WR, MEM_RD, MEM_CONFLICT), trace_entry_t packed struct {kind, idx, data, time}, mask bit-index constants.
- Sub-module trace_fifo_2w1r: 2-write/1-read FWFT FIFO of trace_entry_t with level output.
- Top handles decode, timestamp, drop policy and counters.

Test Plan:
- Reset, then reg_write_sig=1, reg_num=5, reg_data=32'h0000_000A at stamp 3 -> next cycle trace_valid=1, kind=0, idx=5, data=0xA, time=3, level=1.
- Same cycle wr=1, addr=9'd20, wr_data=32'hDEAD_BEEF plus reg write x7=1 -> FIFO order MEM_WR(20, DEADBEEF) then REG_WR(7, 1), level=2.
- wr=1 and rd=1, addr=9'd4, wr_data=32'h11 -> kind=3, idx=4, data=0x11; kind_mask=3'b000 still captures it.
- trace_ready=0, DEPTH=16, push 18 single events -> level=16, overflow=1, drop_count=2; a dual event with 1 slot free pushes the memory event only and drop_count goes +1.
- Full FIFO with trace_ready=1 and a dual event in the same cycle -> one pop, one push (memory event), one drop; level stays 16.
- Pulse clear while full with an event present -> level=0, trace_valid=0, overflow=0, drop_count=0; timestamp continues uninterrupted.
